// File: rtl/skolem_pkg.sv
// Shared definitions for the Skolem-function sweep checker.
//
// Contents:
//   DefWidth      - default bit-width of s, t and x
//   DefSettleCyc  - default number of settle cycles before skolem_out is sampled
//   SettleCntW    - width of the settle down-counter (SETTLE_CYC is 1..15)
//   sweep_state_e - sweep controller FSM states
package skolem_pkg;

    localparam int unsigned DefWidth     = 4;
    localparam int unsigned DefSettleCyc = 1;
    localparam int unsigned SettleCntW   = 4;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSettle,
        StCheck,
        StDone
    } sweep_state_e;

endpackage

// File: rtl/shl_ule_check.sv
// Combinational bvshl / unsigned-less-or-equal check: ok = ((x << s) <= t).
//
// The shift result is truncated to WIDTH bits and is zero once s >= WIDTH,
// which is the bit-vector semantics of a logical left shift.
//
// Ports:
//   x  - candidate value returned by the Skolem function
//   s  - shift amount
//   t  - upper bound
//   ok - 1 when the shifted candidate does not exceed t
module shl_ule_check #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] t,
    output logic             ok
);

    logic [WIDTH-1:0] y;

    always_comb begin
        y = '0;
        // Shift amounts of WIDTH or more push every bit out.
        if (32'(s) < WIDTH) begin
            y = x << s;
        end
    end

    assign ok = (y <= t);

endmodule

// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive sweep controller for an external Skolem-function block.
//
// Every vector {t, s} in 0 .. 2^(2*WIDTH)-1 is driven on skolem_in, given
// SETTLE_CYC cycles to settle, then the returned candidate x is checked with
// (x << s) <= t. Failures are counted and the lowest failing vector is kept.
// One vector takes DRIVE + SETTLE_CYC + CHECK = 2 + SETTLE_CYC cycles.
//
// Ports:
//   clk            - clock, rising edge
//   rst            - synchronous active-high reset
//   start          - one-cycle sweep request, honoured only in idle
//   abort          - terminate a running sweep (wins over start in idle)
//   skolem_in      - {t, s} vector driven to the Skolem block, held in idle
//   skolem_out     - candidate x returned combinationally by the Skolem block
//   busy           - sweep in progress
//   done           - one-cycle pulse at sweep completion or abort
//   pass           - valid with done: full sweep finished with no failures
//   fail_cnt       - number of failing vectors seen so far
//   first_fail_vld - at least one failure recorded
//   first_fail_vec - lowest-indexed failing vector
module skolem_sweep_ctrl
    import skolem_pkg::*;
#(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned SETTLE_CYC = DefSettleCyc
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic [2*WIDTH-1:0] skolem_in,
    input  logic [WIDTH-1:0]   skolem_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   fail_cnt,
    output logic               first_fail_vld,
    output logic [2*WIDTH-1:0] first_fail_vec
);

    localparam int unsigned VecW = 2 * WIDTH;
    // One extra bit so that a sweep where every vector fails does not wrap.
    localparam int unsigned CntW = 2 * WIDTH + 1;
    localparam logic [SettleCntW-1:0] SettleInit = SettleCntW'(SETTLE_CYC);

    sweep_state_e          state_q;
    logic [VecW-1:0]       vec_q;
    logic [SettleCntW-1:0] settle_q;

    logic                  chk_ok;
    logic [CntW-1:0]       fail_cnt_nxt;

    // skolem_in equals vec_q throughout SETTLE and CHECK, so the check sees
    // exactly the vector that the Skolem block is answering.
    shl_ule_check #(
        .WIDTH (WIDTH)
    ) u_check (
        .x  (skolem_out),
        .s  (skolem_in[WIDTH-1:0]),
        .t  (skolem_in[VecW-1:WIDTH]),
        .ok (chk_ok)
    );

    assign fail_cnt_nxt = fail_cnt + CntW'(!chk_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            vec_q          <= '0;
            settle_q       <= '0;
            skolem_in      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_cnt       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
        end else begin
            done <= 1'b0;
            if (busy && abort) begin
                // Abort pre-empts whatever the current state would do, including
                // a pending check, so results reflect only completed vectors.
                state_q <= StDone;
                busy    <= 1'b0;
                done    <= 1'b1;
                pass    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start && !abort) begin
                            fail_cnt       <= '0;
                            first_fail_vld <= 1'b0;
                            first_fail_vec <= '0;
                            pass           <= 1'b0;
                            vec_q          <= '0;
                            busy           <= 1'b1;
                            state_q        <= StDrive;
                        end
                    end
                    StDrive: begin
                        skolem_in <= vec_q;
                        settle_q  <= SettleInit;
                        state_q   <= StSettle;
                    end
                    StSettle: begin
                        settle_q <= settle_q - SettleCntW'(1);
                        if (settle_q == SettleCntW'(1)) begin
                            state_q <= StCheck;
                        end
                    end
                    StCheck: begin
                        if (!chk_ok) begin
                            fail_cnt <= fail_cnt_nxt;
                            if (!first_fail_vld) begin
                                first_fail_vld <= 1'b1;
                                first_fail_vec <= vec_q;
                            end
                        end
                        if (&vec_q) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (fail_cnt_nxt == '0);
                        end else begin
                            vec_q   <= vec_q + VecW'(1);
                            state_q <= StDrive;
                        end
                    end
                    StDone: begin
                        // start arriving here is deliberately dropped.
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
// Self-checking bench for skolem_sweep_ctrl. Two instances (SETTLE_CYC 1 and 3)
// share stimulus and one Skolem lookup table; a cycle-indexed arithmetic model
// predicts every output of both on every cycle.
module tb_skolem_sweep_ctrl;

    localparam int W   = 4;
    localparam int N   = 256;
    localparam int SC0 = 1;
    localparam int SC1 = 3;
    localparam int P0  = SC0 + 2;
    localparam int P1  = SC1 + 2;

    typedef struct packed {
        logic [7:0] sk;
        logic       busy;
        logic       done;
        logic       pass;
        logic [8:0] fc;
        logic       ffv;
        logic [7:0] ffvec;
    } exp_t;

    // ph: 0 = cleared by reset, 1 = sweeping, 2 = done cycle, 3 = idle holding results
    // j: cycle index since the accepted start (cycle 1 follows the start edge)
    // stop: cycle index of the done cycle
    typedef struct packed {
        int         ph;
        int         j;
        int         stop;
        logic       ab;
        logic [7:0] prev;
        exp_t       hold;
    } mst_t;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic [3:0] lut [N];
    int   pcnt [N+1];
    int   ffirst;
    int   n_cmp, n_bad;
    logic cmp_en;
    mst_t m0, m1;

    logic [7:0] sk0, sk1, ffvec0, ffvec1;
    logic [3:0] so0, so1;
    logic       busy0, busy1, done0, done1, pass0, pass1, ffv0, ffv1;
    logic [8:0] fc0, fc1;

    assign so0 = lut[sk0];
    assign so1 = lut[sk1];

    always #5 clk = ~clk;

    skolem_sweep_ctrl #(.WIDTH(W), .SETTLE_CYC(SC0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .skolem_in(sk0), .skolem_out(so0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_cnt(fc0), .first_fail_vld(ffv0), .first_fail_vec(ffvec0)
    );

    skolem_sweep_ctrl #(.WIDTH(W), .SETTLE_CYC(SC1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .skolem_in(sk1), .skolem_out(so1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_cnt(fc1), .first_fail_vld(ffv1), .first_fail_vec(ffvec1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Vector v = {t, s}; fails when ((x << s) mod 2^W) > t, shift of W or more gives 0.
    function automatic bit vec_fails(input int v, input int x);
        int s, t, y;
        s = v % 16;
        t = v / 16;
        y = (s >= W) ? 0 : (x * (1 << s)) % 16;
        return y > t;
    endfunction

    task automatic compute_model();
        pcnt[0] = 0;
        ffirst  = 1 << 30;
        for (int i = 0; i < N; i++) begin
            pcnt[i+1] = pcnt[i] + (vec_fails(i, int'(lut[i])) ? 1 : 0);
            if (vec_fails(i, int'(lut[i])) && ffirst > i) ffirst = i;
        end
    endtask

    task automatic set_lut_const(input logic [3:0] x);
        for (int i = 0; i < N; i++) lut[i] = x;
        compute_model();
    endtask

    task automatic set_lut_rand();
        for (int i = 0; i < N; i++)
            lut[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        compute_model();
    endtask

    function automatic exp_t model_out(input mst_t m, input int p);
        exp_t e;
        int   lim, ck, je, v;
        e = '0;
        if (m.ph == 3) return m.hold;
        if (m.ph != 1 && m.ph != 2) return e;
        // Checks land on cycles p, 2p, ...; an abort cycle's check is dropped.
        lim = m.j - 1;
        if (m.ab && (m.stop - 2) < lim) lim = m.stop - 2;
        ck = lim / p;
        if (ck > N) ck = N;
        e.fc    = 9'(pcnt[ck]);
        e.ffv   = (ffirst < ck);
        e.ffvec = e.ffv ? 8'(ffirst) : 8'h00;
        // Vector i appears on skolem_in from cycle i*p+2; frozen by an abort.
        je = m.j;
        if (m.ab && (m.stop - 1) < je) je = m.stop - 1;
        if (je >= 2) begin
            v = (je - 2) / p;
            if (v > N - 1) v = N - 1;
            e.sk = 8'(v);
        end else begin
            e.sk = m.prev;
        end
        e.busy = (m.ph == 1);
        e.done = (m.ph == 2);
        e.pass = (m.ph == 2) && !m.ab && (pcnt[N] == 0);
        return e;
    endfunction

    function automatic mst_t model_step(input mst_t m, input int p);
        mst_t n;
        exp_t cur;
        n = m;
        if (rst) begin
            n = '0;
            return n;
        end
        cur = model_out(m, p);
        case (m.ph)
            1: begin
                if (abort) begin
                    n.ab   = 1'b1;
                    n.stop = m.j + 1;
                end
                n.j = m.j + 1;
                if (n.j == n.stop) n.ph = 2;
            end
            2: begin
                n.hold      = cur;
                n.hold.busy = 1'b0;
                n.hold.done = 1'b0;
                n.ph        = 3;
            end
            default: begin
                if (start && !abort) begin
                    n.prev = cur.sk;
                    n.ph   = 1;
                    n.j    = 1;
                    n.stop = N * p + 1;
                    n.ab   = 1'b0;
                end
            end
        endcase
        return n;
    endfunction

    always @(posedge clk) begin
        m0 <= model_step(m0, P0);
        m1 <= model_step(m1, P1);
    end

    task automatic check_outs(input string tag, input exp_t e, input logic [7:0] sk,
                              input logic bz, input logic dn, input logic ps,
                              input logic [8:0] fc, input logic fv, input logic [7:0] fvec);
        chk({tag, ".skolem_in"}, 32'(sk), 32'(e.sk));
        chk({tag, ".busy"}, 32'(bz), 32'(e.busy));
        chk({tag, ".done"}, 32'(dn), 32'(e.done));
        chk({tag, ".pass"}, 32'(ps), 32'(e.pass));
        chk({tag, ".fail_cnt"}, 32'(fc), 32'(e.fc));
        chk({tag, ".first_fail_vld"}, 32'(fv), 32'(e.ffv));
        chk({tag, ".first_fail_vec"}, 32'(fvec), 32'(e.ffvec));
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check_outs("d1", model_out(m0, P0), sk0, busy0, done0, pass0, fc0, ffv0, ffvec0);
            check_outs("d3", model_out(m1, P1), sk1, busy1, done1, pass1, fc1, ffv1, ffvec1);
        end
    end

    function automatic bit both_idle();
        return (m0.ph == 0 || m0.ph == 3) && (m1.ph == 0 || m1.ph == 3);
    endfunction

    // e0/e1: edges from the start edge to the edge that raises done (-1 if none).
    task automatic run_sweep(input int abort_at, input int stray_at, input bit start_on_done,
                             output int e0, output int e1);
        int cyc;
        e0 = -1;
        e1 = -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!both_idle() && cyc < 2000) begin
            abort = (cyc == abort_at);
            start = (cyc == stray_at) || (start_on_done && done0);
            if (done0 && e0 < 0) e0 = cyc - 1;
            if (done1 && e1 < 0) e1 = cyc - 1;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        abort = 1'b0;
        if (!both_idle()) chk("sweep_timeout", 32'(cyc), 32'd0);
    endtask

    initial begin
        int e0, e1, hi;
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        n_cmp  = 0;
        n_bad  = 0;
        cmp_en = 1'b0;
        set_lut_const(4'h0);
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst.busy", 32'(busy0), 32'd0);
        chk("rst.skolem_in", 32'(sk1), 32'd0);
        chk("rst.fail_cnt", 32'(fc0), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // x = 0: never fails; stray starts mid-sweep and on done are ignored.
        chk("pin.x0.cnt", 32'(pcnt[N]), 32'd0);
        run_sweep(0, 50, 1'b1, e0, e1);
        chk("x0.latency.s1", 32'(e0), 32'd768);
        chk("x0.latency.s3", 32'(e1), 32'd1280);
        chk("x0.pass", 32'(pass0), 32'd1);
        chk("x0.fail_cnt", 32'(fc0), 32'd0);
        chk("x0.first_fail_vld", 32'(ffv1), 32'd0);

        // x = F
        set_lut_const(4'hF);
        chk("pin.xF.cnt", 32'(pcnt[N]), 32'd49);
        chk("pin.xF.first", 32'(ffirst), 32'd0);
        run_sweep(0, 0, 1'b0, e0, e1);
        chk("xF.fail_cnt", 32'(fc0), 32'd49);
        chk("xF.first_fail_vec", 32'(ffvec1), 32'h00);
        chk("xF.pass", 32'(pass1), 32'd0);

        // x = 1
        set_lut_const(4'h1);
        hi = 0;
        for (int v = 0; v < N; v++) if ((v % 16) >= W && vec_fails(v, 1)) hi++;
        chk("pin.x1.s_ge_w", 32'(hi), 32'd0);
        chk("pin.x1.cnt", 32'(pcnt[N]), 32'd15);
        run_sweep(0, 0, 1'b0, e0, e1);
        chk("x1.fail_cnt", 32'(fc1), 32'd15);
        chk("x1.first_fail_vec", 32'(ffvec0), 32'h00);

        // Abort during cycle 100, x = F
        set_lut_const(4'hF);
        run_sweep(100, 40, 1'b0, e0, e1);
        chk("abort.done_at.s1", 32'(e0), 32'd100);
        chk("abort.done_at.s3", 32'(e1), 32'd100);
        chk("abort.pass", 32'(pass0), 32'd0);
        chk("abort.busy", 32'(busy0), 32'd0);
        chk("abort.fail_cnt.s1", 32'(fc0), 32'd9);
        chk("abort.fail_cnt.s3", 32'(fc1), 32'd7);

        // abort and start together in idle: nothing starts
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start.busy", 32'(busy0 | busy1), 32'd0);

        // Reset mid-sweep, then a full sweep
        set_lut_rand();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (299) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst.busy", 32'(busy0 | busy1), 32'd0);
        chk("midrst.fail_cnt", 32'(fc0), 32'd0);
        chk("midrst.skolem_in", 32'(sk0), 32'd0);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("midrst.nodone", 32'(done0 | done1), 32'd0);
        end
        run_sweep(0, 0, 1'b0, e0, e1);
        chk("midrst.latency.s1", 32'(e0), 32'd768);

        // Random Skolem tables, some sweeps aborted at random points
        for (int k = 0; k < 4; k++) begin
            set_lut_rand();
            run_sweep((k % 2 == 1) ? int'($urandom_range(1, 1300)) : 0,
                      int'($urandom_range(2, 700)), 1'b0, e0, e1);
            repeat (3) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/skolem_sweep_ctrl.md
SKOLEM_SWEEP_CTRL -- requirements
Module: skolem_sweep_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the bit-width of s, t and x.
REQ-002 SHALL have parameter SETTLE_CYC, default 1, range 1..15, meaning the number of wait cycles after a vector is driven before skolem_out is sampled.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a sweep.
REQ-006 SHALL have port abort, input, 1 bit: terminate the current sweep.
REQ-007 SHALL have port skolem_in, output, 2*WIDTH bits: vector driven to the Skolem-function block; s = [WIDTH-1:0], t = [2*WIDTH-1:WIDTH].
REQ-008 SHALL have port skolem_out, input, WIDTH bits: candidate x returned combinationally by the Skolem-function block.
REQ-009 SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when a sweep completes or is aborted.
REQ-011 SHALL have port pass, output, 1 bit: valid when done is high; 1 = full sweep completed with zero failures.
REQ-012 SHALL have port fail_cnt, output, 2*WIDTH+1 bits: number of failing vectors.
REQ-013 SHALL have port first_fail_vld, output, 1 bit: at least one failure has been recorded.
REQ-014 SHALL have port first_fail_vec, output, 2*WIDTH bits: the lowest-indexed failing vector.

Function
REQ-015 SHALL implement the FSM states IDLE, DRIVE, SETTLE, CHECK and DONE.
REQ-016 IDLE SHALL, on start, clear fail_cnt, first_fail_vld and first_fail_vec, set the vector to 0 and go to DRIVE.
REQ-017 DRIVE SHALL present the vector on skolem_in, load the settle counter with SETTLE_CYC and go to SETTLE.
REQ-018 SETTLE SHALL decrement the settle counter and go to CHECK when the counter reaches 0.
REQ-019 CHECK SHALL sample skolem_out as x and evaluate the check defined in REQ-020.
REQ-020 CHECK SHALL compute y = (x << s) truncated to WIDTH bits, with y = 0 when s >= WIDTH; the vector fails when the unsigned compare y <= t is false.
REQ-021 The invertibility condition (exists x: (x<<s) <= t) is always true because x = 0 satisfies it; therefore every vector SHALL be checked.
REQ-022 On a failure, CHECK SHALL increment fail_cnt; if first_fail_vld is 0, it SHALL load first_fail_vec with the vector and set first_fail_vld.
REQ-023 CHECK SHALL go to DONE when the vector is all-ones; otherwise it SHALL increment the vector and go to DRIVE.
REQ-024 The cycle count per vector SHALL be 2+SETTLE_CYC; a full sweep SHALL take 2^(2*WIDTH)*(2+SETTLE_CYC) cycles from the cycle after start until done.
REQ-025 DONE SHALL assert done for exactly one cycle, set pass = (fail_cnt == 0) and complete_flag, then return to IDLE.
REQ-026 busy SHALL be high in DRIVE, SETTLE and CHECK, and low in IDLE and DONE.
REQ-027 start SHALL be ignored while busy is high.
REQ-028 start arriving in the same cycle as done SHALL be ignored.
REQ-029 abort while busy SHALL cause a move to DONE on the next edge with pass = 0; counters SHALL hold the values accumulated so far.
REQ-030 When abort and start are both asserted in IDLE, abort SHALL win and no sweep SHALL start.
REQ-031 fail_cnt SHALL be wide enough to hold 2^(2*WIDTH) failures without wrap.
REQ-032 skolem_in SHALL hold its last value in IDLE.
REQ-033 Results SHALL hold until the next accepted start.

Reset
REQ-034 When rst is high at a clock edge, the state SHALL become IDLE.
REQ-035 Reset SHALL clear skolem_in, busy, done, pass, fail_cnt, first_fail_vld, first_fail_vec, the vector register and the settle counter to 0.
REQ-036 Reset mid-sweep SHALL discard all progress and SHALL NOT produce a done pulse.

Structure
REQ-037 The FSM state enum and the default WIDTH and SETTLE_CYC constants SHALL live in the shared package skolem_pkg.
REQ-038 The shift-compare check SHALL be the combinational sub-module shl_ule_check (inputs x, s, t; output ok), reusable for other bvshl checkers.
REQ-039 The Skolem-function block under test SHALL remain external to this module.

Verification
REQ-040 Model x = 0, WIDTH = 4, SETTLE_CYC = 1 -> done 768 cycles after start, pass = 1, fail_cnt = 0, first_fail_vld = 0.
REQ-041 Model x = 4'hF -> pass = 0, fail_cnt = 49, first_fail_vec = 8'h00.
REQ-042 Model x = 4'h1 -> fail_cnt = 15, first_fail_vec = 8'h00; a vector with s >= 4 never fails.
REQ-043 Abort asserted at cycle 100 of a sweep -> done on the next cycle, pass = 0, busy low; start pulses during the sweep change nothing.
REQ-044 rst pulsed mid-sweep -> all outputs 0, no done pulse; a following start runs a full 768-cycle sweep.
REQ-045 SETTLE_CYC = 3 with x = 0 -> done 1280 cycles after start; skolem_in is stable for 5 cycles per vector.
